// File: rtl/fifo_umbral.sv
// Single-lane transaction FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_ERR_STICKY_EN to hold fifo_error until reset or init; otherwise it is a one-cycle pulse.
module fifo_umbral #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned LENGTH     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [LENGTH-1:0]     umbral_af,
    input  logic [LENGTH-1:0]     umbral_ae,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [LENGTH-1:0]     count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error
);

    localparam int unsigned      DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [LENGTH-1:0] DEPTH_L = LENGTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LENGTH-1:0]     af_q;
    logic [LENGTH-1:0]     ae_q;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  err_evt;

    // Status flags are decoded straight from occupancy and the latched thresholds.
    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == DEPTH_L);
    assign almost_full  = (count >= af_q);
    assign almost_empty = (count <= ae_q);

    // A full FIFO still accepts a push when the same-cycle pop frees a slot.
    assign pop_ok  = pop && !fifo_empty && !init;
    assign push_ok = push && !init && (!fifo_full || pop_ok);
    assign err_evt = !init && ((push && fifo_full && !pop) || (pop && fifo_empty));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            fifo_error <= 1'b0;
            af_q       <= DEPTH_L;
            ae_q       <= '0;
        end else if (init) begin
            af_q       <= umbral_af;
            ae_q       <= umbral_ae;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_out  <= 1'b0;
            fifo_error <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LENGTH'(1);
                2'b01:   count <= count - LENGTH'(1);
                default: count <= count;
            endcase
`ifdef FIFO_ERR_STICKY_EN
            fifo_error <= fifo_error || err_evt;
`else
            fifo_error <= err_evt;
`endif
        end
    end

    // Storage is never cleared; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule
